// File: rtl/sha2_block_engine.sv
`default_nettype none
// ============================================================================
// Module : sha2_block_engine
// Iterative SHA-224/SHA-256 block compression with a chaining state.
// Rev    : 1.0
// ============================================================================
module sha2_block_engine #(
  parameter int ROUNDS_PER_CLK = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         first_blk,
  input  logic         mode224,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  generate
    if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 4) begin : g_bad_rpc
      $error("sha2_block_engine: ROUNDS_PER_CLK must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [6:0] c_step = 7'(ROUNDS_PER_CLK);

  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] c_iv256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] c_iv224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_t;
  logic        r_mode224;
  logic [31:0] r_w       [16];
  logic [31:0] r_var     [8];
  logic [31:0] r_h       [8];
  logic [31:0] w_w_nxt   [16];
  logic [31:0] w_var_nxt [8];
  logic [31:0] w_hsum    [8];
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [31:0] w_new;
  logic [5:0]  w_kidx;

  assign busy = (r_state != IDLE);

  // R rounds chained combinationally; var index 0..7 = a..h, window slot 0 = W[t].
  always_comb begin
    w_w_nxt   = r_w;
    w_var_nxt = r_var;
    w_t1      = '0;
    w_t2      = '0;
    w_new     = '0;
    w_kidx    = '0;
    for (int k = 0; k < ROUNDS_PER_CLK; k++) begin
      w_kidx = r_t[5:0] + 6'(k);
      w_t1   = w_var_nxt[7] + big_sigma1(w_var_nxt[4])
             + ((w_var_nxt[4] & w_var_nxt[5]) ^ (~w_var_nxt[4] & w_var_nxt[6]))
             + c_k[w_kidx] + w_w_nxt[0];
      w_t2   = big_sigma0(w_var_nxt[0])
             + ((w_var_nxt[0] & w_var_nxt[1]) ^ (w_var_nxt[0] & w_var_nxt[2]) ^ (w_var_nxt[1] & w_var_nxt[2]));
      w_new  = small_sigma1(w_w_nxt[14]) + w_w_nxt[9] + small_sigma0(w_w_nxt[1]) + w_w_nxt[0];
      for (int j = 7; j > 0; j--) begin
        w_var_nxt[j] = w_var_nxt[j-1];
      end
      w_var_nxt[4] = w_var_nxt[4] + w_t1;
      w_var_nxt[0] = w_t1 + w_t2;
      for (int j = 0; j < 15; j++) begin
        w_w_nxt[j] = w_w_nxt[j+1];
      end
      w_w_nxt[15] = w_new;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_hsum[i] = r_h[i] + r_var[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ROUND;
      ROUND:   if (r_t + c_step == 7'd64) w_state_nxt = FINAL;
      FINAL:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t       <= '0;
      r_mode224 <= 1'b0;
      done      <= 1'b0;
      digest    <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        r_var[i] <= '0;
        r_h[i]   <= c_iv256[i];
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_t <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= block_in[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              if (first_blk) begin
                r_var[i] <= mode224 ? c_iv224[i] : c_iv256[i];
                r_h[i]   <= mode224 ? c_iv224[i] : c_iv256[i];
              end else begin
                r_var[i] <= r_h[i];
              end
            end
            if (first_blk) r_mode224 <= mode224;
          end
        end
        ROUND: begin
          r_var <= w_var_nxt;
          r_w   <= w_w_nxt;
          r_t   <= r_t + c_step;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) r_h[i] <= w_hsum[i];
          // SHA-224 truncates the visible digest only; H7 keeps chaining.
          digest <= {w_hsum[0], w_hsum[1], w_hsum[2], w_hsum[3], w_hsum[4], w_hsum[5], w_hsum[6],
                     r_mode224 ? 32'h0 : w_hsum[7]};
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha2_block_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_sha2_block_engine
// Scoreboard bench driving R=1, R=2 and R=4 engines with shared stimulus.
// Rev    : 1.0
// ============================================================================
module tb_sha2_block_engine;

  typedef struct {
    logic [255:0] dig;
    bit           chk;
    int           cyc;
  } exp_t;

  localparam logic [511:0] c_abc   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_empty = {32'h80000000, 480'h0};
  localparam logic [511:0] c_m1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_m2    = {480'h0, 32'h000001c0};

  localparam logic [255:0] c_d_abc256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] c_d_abc224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] c_d_empty  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] c_d_two    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         first_blk;
  logic         mode224;
  logic [511:0] block_in;
  logic         busy1, busy2, busy4;
  logic         done1, done2, done4;
  logic [255:0] digest1, digest2, digest4;

  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha2_block_engine #(.ROUNDS_PER_CLK(1)) u_r1 (
    .clk(clk), .rst(rst), .start(start), .first_blk(first_blk), .mode224(mode224),
    .block_in(block_in), .busy(busy1), .done(done1), .digest(digest1)
  );
  sha2_block_engine #(.ROUNDS_PER_CLK(2)) u_r2 (
    .clk(clk), .rst(rst), .start(start), .first_blk(first_blk), .mode224(mode224),
    .block_in(block_in), .busy(busy2), .done(done2), .digest(digest2)
  );
  sha2_block_engine #(.ROUNDS_PER_CLK(4)) u_r4 (
    .clk(clk), .rst(rst), .start(start), .first_blk(first_blk), .mode224(mode224),
    .block_in(block_in), .busy(busy4), .done(done4), .digest(digest4)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic on_done(input int id, input logic [255:0] dig, input logic bsy);
    exp_t e;
    int   sz;
    case (id)
      1:       sz = q1.size();
      2:       sz = q2.size();
      default: sz = q4.size();
    endcase
    check($sformatf("done_expected_r%0d", id), 256'(sz != 0), 256'd1);
    if (sz != 0) begin
      case (id)
        1:       e = q1.pop_front();
        2:       e = q2.pop_front();
        default: e = q4.pop_front();
      endcase
      if (e.chk) check($sformatf("digest_r%0d", id), dig, e.dig);
      check($sformatf("done_cycle_r%0d", id), 256'(cyc), 256'(e.cyc));
      check($sformatf("busy_at_done_r%0d", id), 256'(bsy), 256'd0);
    end
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) on_done(1, digest1, busy1);
    if (done2 === 1'b1) on_done(2, digest2, busy2);
    if (done4 === 1'b1) on_done(4, digest4, busy4);
  end

  // Drives one start pulse; expected done cycle is start edge + 64/R + 1.
  task automatic send(input logic [511:0] blk, input logic fb, input logic m,
                      input logic [255:0] exp_dig, input bit chk_dig, input bit accepted);
    exp_t e;
    block_in  = blk;
    first_blk = fb;
    mode224   = m;
    start     = 1'b1;
    if (accepted) begin
      e.dig = exp_dig;
      e.chk = chk_dig;
      e.cyc = cyc + 1 + 65; q1.push_back(e);
      e.cyc = cyc + 1 + 33; q2.push_back(e);
      e.cyc = cyc + 1 + 17; q4.push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    block_in  = ~blk;
    first_blk = ~fb;
    mode224   = ~m;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q1.size() + q2.size() + q4.size()) != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_pending", 256'(q1.size() + q2.size() + q4.size()), 256'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_digest_r1"}, digest1, 256'd0);
    check({tag, "_digest_r2"}, digest2, 256'd0);
    check({tag, "_digest_r4"}, digest4, 256'd0);
    check({tag, "_busy"}, 256'({busy1, busy2, busy4}), 256'd0);
    check({tag, "_done"}, 256'({done1, done2, done4}), 256'd0);
  endtask

  task automatic check_busy(input string tag);
    check({tag, "_busy"}, 256'({busy1, busy2, busy4}), 256'd7);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    first_blk = 1'b0;
    mode224   = 1'b0;
    block_in  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    send(c_abc, 1'b1, 1'b0, c_d_abc256, 1'b1, 1'b1);
    check_busy("abc256");
    wait_idle(200);

    send(c_abc, 1'b1, 1'b1, c_d_abc224, 1'b1, 1'b1);
    wait_idle(200);

    send(c_empty, 1'b1, 1'b0, c_d_empty, 1'b1, 1'b1);
    wait_idle(200);

    // Second block issued in the R=1 done cycle; mode224 must be ignored with first_blk=0.
    send(c_m1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    repeat (65) @(negedge clk);
    send(c_m2, 1'b0, 1'b1, c_d_two, 1'b1, 1'b1);
    wait_idle(200);

    send(c_abc, 1'b1, 1'b0, c_d_abc256, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    send(c_empty, 1'b1, 1'b1, '0, 1'b0, 1'b0);
    wait_idle(200);
    check("stable_digest_r1", digest1, c_d_abc256);
    check("stable_digest_r2", digest2, c_d_abc256);
    check("stable_digest_r4", digest4, c_d_abc256);

    send(c_abc, 1'b1, 1'b1, c_d_abc224, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    q1.delete();
    q2.delete();
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    check_idle("midreset");
    repeat (80) @(negedge clk);

    send(c_empty, 1'b0, 1'b1, c_d_empty, 1'b1, 1'b1);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha2_block_engine.md
# sha2_block_engine

Iterative SHA-224/SHA-256 compression engine: accepts a padded 512-bit block, runs all 64 rounds internally (own round counter, K-constant ROM and 16-word message-schedule window), and folds the result into a chaining state so that multi-block messages can be hashed back-to-back. It replaces the externally sequenced Wt/Kt compression datapath and sits between the KDF feedback-mode controller (block producer) and the PRF output register (digest consumer). Throughput is set by a rounds-per-clock parameter.

## Interface
- ROUNDS_PER_CLK, 1, rounds per clock; legal values 1, 2, 4; any other value is a synthesis-time error
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request to compress block_in; accepted only when busy=0
- first_blk  in  1  sampled with accepted start: 1 = load IV into chaining state before compressing, 0 = continue from current chaining state
- mode224  in  1  sampled with accepted start when first_blk=1: 1 = SHA-224 IV and output, 0 = SHA-256
- block_in  in  512  padded message block; block_in[511:480] = W0 … block_in[31:0] = W15; sampled only on accepted start
- busy  out  1  high while a block is in flight
- done  out  1  one-cycle pulse: digest updated
- digest  out  256  chaining value after last completed block; digest[255:224] = H0

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE: busy=0. On start=1: latch block_in into schedule window W[0..15]; if first_blk, latch mode224 and load working vars a..h from IV (SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4) and also load chaining H0..H7 from the same IV; else load a..h from current H0..H7 and keep latched mode. Round counter t=0. Go ROUND.
- ROUND: each cycle performs ROUNDS_PER_CLK consecutive rounds t..t+R-1 (FIPS 180-4: T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W[t], T2 = Σ0(a)+Maj(a,b,c)); window advances R words using W[t+16] = σ1(W[t+14])+W[t+9]+σ0(W[t+1])+W[t]. All additions modulo 2^32. t += R; when t reaches 64, go FINAL.
- FINAL: Hi <= Hi + var_i (mod 2^32); digest <= {H0..H7} updated; in SHA-224 mode digest[31:0] forced to 0 (H7 still kept internally for chaining). done=1 for this cycle. Go IDLE.
- start while busy=1: ignored, no effect on in-flight block.
- first_blk=0 immediately after reset: continues from reset chaining state (SHA-256 IV), equivalent to first_blk=1 with mode224=0.
- Reset mid-operation: block abandoned, no done pulse, all state to reset values.

## Timing
- Reset values: busy=0, done=0, digest=0, state IDLE, t=0, H0..H7 = SHA-256 IV, latched mode = SHA-256.
- Start accepted at edge E0 -> busy=1 from E0; rounds on edges E1..E(64/R); FINAL on edge E(64/R+1): done=1 and new digest visible after that edge, busy=0 from same edge.
- Latency start-accept to done: 64/R+1 cycles (65 / 33 / 17).
- done and busy=0 coincide, so start may be asserted in the done cycle; accepted at next edge (back-to-back, zero idle cycles; block period 64/R+1).
- digest stable between done pulses; never shows intermediate working vars.

## Test plan
- R=1, first_blk=1, mode224=0, block_in = 61626380 000…0 00000018 ("abc") -> done exactly 65 cycles after start edge, digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same block, mode224=1 -> digest = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Empty message (block 80000000, rest 0), R=2 and R=4 builds -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, done after 33 / 17 cycles.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 first_blk=1, block 2 first_blk=0 issued in block 1 done cycle -> final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, one done per block.
- start pulsed with different block_in during busy -> ignored, "abc" digest unchanged, single done.
- rst asserted at round 30 of an "abc" compression -> no done, digest=0, busy=0; subsequent empty-message block with first_blk=0 yields the SHA-256 empty-string digest.
